scpu_boot_mem: RTL
==================

// Module: scpu_boot_mem
// PURPOSE
//  Byte-wide program/data memory with built-in boot loader that sits directly upstream of SERIAL_CPU_8BIT.
//  Receives an image over a valid/ready byte stream and writes it from address 0.
//  Then pulses the CPU start input and serves the CPU's i_addr/d_addr byte accesses.
//  16-bit instructions/data are stored little-endian (low byte at even address).
// PARAMETERS
//  ADDR_W     9      byte address width; must match CPU i_addr/d_addr width
//  DEPTH      512    bytes of storage; DEPTH <= 2**ADDR_W
// PORTS
//  clk        in   1       system clock, all logic rising-edge
//  rst_n      in   1       asynchronous active-low reset
//  ld_valid   in   1       loader byte valid
//  ld_ready   out  1       loader byte accepted when ld_valid & ld_ready
//  ld_data    in   8       loader byte
//  reload     in   1       pulse: abort RUN, return to IDLE for a new image
//  i_addr     in   ADDR_W  CPU instruction byte address
//  i_datain   out  8       instruction byte to CPU
//  d_addr     in   ADDR_W  CPU data byte address
//  d_we       in   1       CPU data write enable
//  d_dataout  in   8       CPU write data
//  d_datain   out  8       data byte to CPU
//  cpu_start  out  1       one-cycle start pulse to CPU
//  busy       out  1       high in any loading state
//  ld_err     out  1       sticky: image length exceeded DEPTH
// BEHAVIOUR
//  Reset: state=IDLE; ld_ready=0, cpu_start=0, busy=0, ld_err=0, i_datain=0, d_datain=0.
//   Memory contents are not reset.
//  FSM states and transitions:
//   IDLE    -> LEN_LO next cycle.
//   LEN_LO  ready=1; on accept, len[7:0]=byte -> LEN_HI.
//   LEN_HI  ready=1; on accept, len[15:8]=byte, wptr=0.
//           -> START if len==0, else -> DATA.
//   DATA    ready=1; on accept, mem[wptr]=byte if wptr<DEPTH, else discard and set ld_err.
//           wptr++, cnt++; -> START when cnt==len-1 accepted.
//   START   cpu_start=1 for exactly one cycle -> RUN.
//   RUN     ready=0; CPU port live; reload -> IDLE next cycle.
//  busy=1 in LEN_LO, LEN_HI and DATA.
//  ld_err clears only on rst_n or on entry to LEN_LO.
//  len==0 skips DATA and starts the existing image.
//  CPU reads: synchronous, 1-cycle latency.
//   i_datain <= mem[i_addr]; d_datain <= mem[d_addr].
//   Addresses >= DEPTH read 8'h00.
//  CPU writes: in RUN only, mem[d_addr] <= d_dataout on d_we; ignored if d_addr >= DEPTH.
//   d_we outside RUN is ignored.
//  Same-cycle d_we and d_addr==i_addr: i_datain and d_datain return the OLD byte (read-before-write).
//  reload mid-DATA has no effect (accepted only in RUN).
//   rst_n assert mid-load aborts immediately to IDLE; partial image stays in memory.
//  Counters: cnt is 16 bits, wptr is ADDR_W+1 bits; neither wraps within a legal len.
// STRUCTURE
//  Shared package/defines (alongside DEFINE_CPU.v): loader state encodings,
//   BOOT_LEN_W=16, default ADDR_W=9.
//  One sub-module: scpu_byte_ram (1W + 2R synchronous byte RAM, read-before-write).
//   Its write port is muxed between loader (DATA) and CPU (RUN) by the FSM.
// TESTING
//  1 Reset then stream 04,00,AB,10,00,3C -> mem[0..3]=AB,10,00,3C;
//    one cpu_start pulse 1 cycle after last accept; busy drops.
//  2 Stream 00,00 -> no DATA bytes accepted; cpu_start pulses the cycle after the 2nd accept.
//  3 In RUN: d_we=1, d_addr=2, d_dataout=CD, then read d_addr=2 -> d_datain=CD one cycle later.
//    Same-cycle i_addr=2 read returns 00 (old byte).
//  4 Length 0x0202 with DEPTH=512 -> ld_err=1 after byte 512.
//    mem[0..511] intact; cpu_start still pulses after byte 514.
//  5 rst_n low after 2 DATA bytes -> outputs at reset values asynchronously.
//    Fresh image loads correctly after release.
//  6 Full CPU run: load LOAD/LOAD/ADD/STORE/HALT program plus data 10AB, 3C00.
//    -> CPU gr3=4CAB; mem store byte pair reads AB,4C.

Source files
------------

// File: rtl/scpu_boot_mem_pkg.sv
// Shared definitions for the scpu boot memory: loader FSM encodings and sizes.
// Latency: n/a (constants and a pure decode function only).
// Backpressure: n/a.
package scpu_boot_mem_pkg;

   // Width of the little-endian length header that prefixes every image.
   localparam int BOOT_LEN_W = 16;

   // Default geometry; ADDR_W must match the CPU i_addr/d_addr width.
   localparam int ADDR_W_DEF = 9;
   localparam int DEPTH_DEF  = 512;

   // Loader FSM encodings.
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LEN_LO = 3'd1;
   localparam logic [2:0] ST_LEN_HI = 3'd2;
   localparam logic [2:0] ST_DATA   = 3'd3;
   localparam logic [2:0] ST_START  = 3'd4;
   localparam logic [2:0] ST_RUN    = 3'd5;

   // True in every state that accepts loader bytes.
   function automatic logic is_load_state(input logic [2:0] st);
      return (st == ST_LEN_LO) || (st == ST_LEN_HI) || (st == ST_DATA);
   endfunction

endpackage

// File: rtl/scpu_byte_ram.sv
// Byte RAM with one write port and two independent synchronous read ports.
// Latency: 1 cycle on both read ports; reads return the pre-write byte on a same-cycle collision.
// Backpressure: none; every cycle accepts one write and two reads.
//
// Ports:
//   clk, rst_n          clock and async active-low reset (read registers only)
//   we, waddr, wdat     write port; caller guarantees waddr < DEPTH
//   ra_addr / ra_dat    read port A (instruction side)
//   rb_addr / rb_dat    read port B (data side)
//   Reads of addresses >= DEPTH return 8'h00.
module scpu_byte_ram #(
   parameter int ADDR_W = 9,
   parameter int DEPTH  = 512
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [7:0]        wdat,
   input  logic [ADDR_W-1:0] ra_addr,
   output logic [7:0]        ra_dat,
   input  logic [ADDR_W-1:0] rb_addr,
   output logic [7:0]        rb_dat
);

   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

   // Storage is deliberately not reset so a partial image survives rst_n.
   logic [7:0] mem [DEPTH];

   logic ra_ok;
   logic rb_ok;

   assign ra_ok = ({1'b0, ra_addr} < DEPTH_L);
   assign rb_ok = ({1'b0, rb_addr} < DEPTH_L);

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdat;
      end
   end

   // Non-blocking reads sample mem before this edge's write lands,
   // which gives read-before-write on address collisions.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ra_dat <= 8'h00;
         rb_dat <= 8'h00;
      end else begin
         ra_dat <= ra_ok ? mem[ra_addr] : 8'h00;
         rb_dat <= rb_ok ? mem[rb_addr] : 8'h00;
      end
   end

endmodule

// File: rtl/scpu_boot_mem.sv
// Program/data byte memory for the serial CPU with an integrated stream boot loader.
// Latency: CPU reads 1 cycle; cpu_start pulses the cycle after the final image byte is accepted.
// Backpressure: ld_ready is high only while a length or image byte is expected; low in IDLE/START/RUN.
//
// Ports:
//   clk, rst_n                  clock and async active-low reset
//   ld_valid/ld_ready/ld_data   image byte stream: len_lo, len_hi, then len data bytes
//   reload                      in RUN, returns to IDLE to take a new image
//   i_addr/i_datain             CPU instruction byte read
//   d_addr/d_we/d_dataout/d_datain  CPU data byte read/write (writes honoured only in RUN)
//   cpu_start                   one-cycle CPU start pulse
//   busy                        high while loading
//   ld_err                      sticky, image longer than DEPTH (excess bytes discarded)
import scpu_boot_mem_pkg::*;

module scpu_boot_mem #(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [7:0]        ld_data,
   input  logic              reload,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [7:0]        i_datain,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic              d_we,
   input  logic [7:0]        d_dataout,
   output logic [7:0]        d_datain,
   output logic              cpu_start,
   output logic              busy,
   output logic              ld_err
);

   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

   logic [2:0]            state;
   logic [2:0]            state_nxt;
   logic [BOOT_LEN_W-1:0] len;
   logic [BOOT_LEN_W-1:0] cnt;
   logic [ADDR_W:0]       wptr;

   logic                  accept;
   logic                  wptr_ok;
   logic                  d_addr_ok;
   logic [BOOT_LEN_W-1:0] len_full;

   logic                  ram_we;
   logic [ADDR_W-1:0]     ram_waddr;
   logic [7:0]            ram_wdat;

   assign ld_ready  = is_load_state(state);
   assign busy      = is_load_state(state);
   assign cpu_start = (state == ST_START);
   assign accept    = ld_valid & ld_ready;

   assign wptr_ok   = (wptr < DEPTH_L);
   assign d_addr_ok = ({1'b0, d_addr} < DEPTH_L);

   // Length as it will be once the high byte currently on ld_data is taken.
   assign len_full  = {ld_data, len[7:0]};

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   state_nxt = ST_LEN_LO;
         ST_LEN_LO: if (accept) state_nxt = ST_LEN_HI;
         ST_LEN_HI: if (accept) state_nxt = (len_full == '0) ? ST_START : ST_DATA;
         ST_DATA:   if (accept && (cnt == len - BOOT_LEN_W'(1))) state_nxt = ST_START;
         ST_START:  state_nxt = ST_RUN;
         ST_RUN:    if (reload) state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         len    <= '0;
         cnt    <= '0;
         wptr   <= '0;
         ld_err <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            // IDLE always advances to LEN_LO, so this is the entry-to-LEN_LO clear.
            ST_IDLE: ld_err <= 1'b0;
            ST_LEN_LO: if (accept) len[7:0] <= ld_data;
            ST_LEN_HI: begin
               if (accept) begin
                  len[15:8] <= ld_data;
                  wptr      <= '0;
                  cnt       <= '0;
               end
            end
            ST_DATA: begin
               if (accept) begin
                  cnt <= cnt + BOOT_LEN_W'(1);
                  // wptr holds at DEPTH once storage is full so excess bytes
                  // can never alias back onto low addresses.
                  if (wptr_ok) begin
                     wptr <= wptr + (ADDR_W+1)'(1);
                  end else begin
                     ld_err <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Single RAM write port: loader owns it in DATA, the CPU owns it in RUN.
   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = '0;
      ram_wdat  = 8'h00;
      if ((state == ST_DATA) && accept && wptr_ok) begin
         ram_we    = 1'b1;
         ram_waddr = wptr[ADDR_W-1:0];
         ram_wdat  = ld_data;
      end else if ((state == ST_RUN) && d_we && d_addr_ok) begin
         ram_we    = 1'b1;
         ram_waddr = d_addr;
         ram_wdat  = d_dataout;
      end
   end

   scpu_byte_ram #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (ram_we),
      .waddr   (ram_waddr),
      .wdat    (ram_wdat),
      .ra_addr (i_addr),
      .ra_dat  (i_datain),
      .rb_addr (d_addr),
      .rb_dat  (d_datain)
   );

endmodule
